// File: rtl/ex_hazard_ctrl.sv
// Load-use stall, taken-branch redirect and operand forwarding control for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module ex_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int ZERO_REG     = 31,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32,
    parameter int WORD_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rn,
    input  logic [REG_ADDR_W-1:0] id_rm,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] ex_rn,
    input  logic [REG_ADDR_W-1:0] ex_rm,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_branch_taken,
    input  logic [WORD_W-1:0]     mem_branch_target,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  pc_sel,
    output logic [WORD_W-1:0]     pc_target,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);
    localparam logic [3:0]            REM_INIT = 4'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       hz_s;

    // The EX write-enable is implied by ex_mem_read for the load-use check.
    logic unused_ex_reg_write_s;
    assign unused_ex_reg_write_s = ex_reg_write;

    function automatic logic [1:0] fwd_sel(
        input logic                  mem_wr,
        input logic [REG_ADDR_W-1:0] mem_dst,
        input logic                  wb_wr,
        input logic [REG_ADDR_W-1:0] wb_dst,
        input logic [REG_ADDR_W-1:0] src
    );
        if (mem_wr && (mem_dst != ZERO_IDX) && (mem_dst == src)) begin
            return 2'b10;
        end else if (wb_wr && (wb_dst != ZERO_IDX) && (wb_dst == src)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Load-use hazard between the ID sources and the EX load destination.
    always_comb begin
        hz_s = id_valid && ex_mem_read && (ex_rd != ZERO_IDX) &&
               ((ex_rd == id_rn) || (ex_rd == id_rm));
    end

    // Next-state and control decode; a taken branch outranks any stall.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_sel      = 1'b0;
        pc_target   = {WORD_W{1'b0}};
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_RUN;
            rem_d       = 4'd0;
        end else if (mem_branch_taken) begin
            pc_sel      = 1'b1;
            pc_target   = mem_branch_target;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = ST_REDIRECT;
            rem_d       = 4'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz_s) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d = ST_STALL;
                            rem_d   = REM_INIT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (rem_q <= 4'd1) begin
                        state_d = ST_RUN;
                        rem_d   = 4'd0;
                    end else begin
                        rem_d   = rem_q - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = 4'd0;
                end
            endcase
        end
    end

    // Forwarding selects for both EX operands, MEM ahead of WB.
    always_comb begin
        if (rst) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end else begin
            fwd_a = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rn);
            fwd_b = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rm);
        end
    end

    // Sequencer state and remaining stall count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (idex_bubble && !rst && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (pc_sel && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = {CNT_W{1'b0}};
    assign flush_count = {CNT_W{1'b0}};
`endif

endmodule
